// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the byte-stream instruction memory loader.
package imem_loader_pkg;
  typedef enum logic {LOAD = 1'b0, DONE = 1'b1} state_t;

  localparam int          DEPTH          = 64;
  localparam logic [31:0] NOP_WORD       = 32'h0000_0000;
  localparam int          BYTES_PER_WORD = 4;
  localparam int          AW             = $clog2(DEPTH);
  localparam int          CW             = $clog2(DEPTH + 1);
  localparam int          IW             = $clog2(BYTES_PER_WORD);
endpackage

// File: rtl/imem_loader_64x32_byte_packer_32.sv
// Big-endian byte packer: collects three bytes and emits a word on the fourth
// byte, or early (low bytes zeroed) when the stream ends mid-word.
module byte_packer_32
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic [31:0] word_out,
  output logic        word_valid,
  output logic        partial
);
  logic [IW-1:0] idx;
  logic [23:0]   hold;

  assign word_valid = accept & ((idx == IW'(BYTES_PER_WORD - 1)) | in_last);
  assign partial    = accept & in_last & (idx != IW'(BYTES_PER_WORD - 1));

  // The current byte bypasses the holding register so the word is complete on its own edge.
  always_comb begin
    word_out = '0;
    case (idx)
      2'd0:    word_out = {in_byte, 24'h0};
      2'd1:    word_out = {hold[23:16], in_byte, 16'h0};
      2'd2:    word_out = {hold[23:8], in_byte, 8'h0};
      default: word_out = {hold, in_byte};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      hold <= '0;
    end else if (clr) begin
      idx  <= '0;
      hold <= '0;
    end else if (accept) begin
      idx <= in_last ? '0 : idx + IW'(1);
      case (idx)
        2'd0:    hold[23:16] <= in_byte;
        2'd1:    hold[15:8]  <= in_byte;
        2'd2:    hold[7:0]   <= in_byte;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/imem_loader_64x32.sv
// Program loader and 64x32 instruction store: holds the core in reset while a
// host streams the image in, then serves combinational fetch reads.
module imem_loader_64x32
  import imem_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_byte,
  input  logic          in_last,
  input  logic          reload,
  input  logic [AW-1:0] ra,
  output logic [31:0]   rd,
  output logic          cpu_rst,
  output logic          load_done,
  output logic [CW-1:0] word_count,
  output logic          err_align,
  output logic          err_overflow
);
  state_t      state, state_nxt;
  logic        accept, clr, word_valid, partial;
  logic [31:0] word_out;
  logic [31:0] mem [DEPTH];

  assign accept = in_valid & in_ready;
  assign clr    = (state == DONE) & reload;

  byte_packer_32 u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .accept     (accept),
    .in_byte    (in_byte),
    .in_last    (in_last),
    .word_out   (word_out),
    .word_valid (word_valid),
    .partial    (partial)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (accept && in_last) state_nxt = DONE;
      DONE: if (reload)            state_nxt = LOAD;
      default:                     state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    cpu_rst   = (state == LOAD);
    load_done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_count   <= '0;
      err_align    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (clr) begin
      word_count   <= '0;
      err_align    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (word_valid) begin
      if (word_count == CW'(DEPTH)) err_overflow <= 1'b1;
      else                          word_count   <= word_count + CW'(1);
      if (partial) err_align <= 1'b1;
    end
  end

  // Storage survives rst/reload; stale words are hidden by the word_count mask on read.
  always_ff @(posedge clk) begin
    if (word_valid && (word_count < CW'(DEPTH)))
      mem[word_count[AW-1:0]] <= word_out;
  end

  assign rd = ({1'b0, ra} < word_count) ? mem[ra] : NOP_WORD;
endmodule
